mips32_mem_arbiter: RTL

Fixed-priority arbiter with a starvation guard that shares the single-port unified instruction/data memory of the `mips_32` pipeline. It serves three requesters: the MEM-stage load/store port, the IF-stage fetch port and an optional debug/loader port. Each handshake issues one registered memory command, and read data is routed back to the owner two cycles later. It sits between the pipeline and the memory array, replacing direct array access.

---
 rtl/mips32_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mips32_mem_arbiter
//
// Shares the single-port unified instruction/data memory of the mips_32
// pipeline between the MEM-stage load/store port (d_*), the IF-stage fetch
// port (i_*) and, optionally, a debug/loader port (x_*).
//
// Arbitration is fixed priority data > fetch > debug. A starvation guard lets
// fetch override data once it has been refused STARVE_MAX consecutive
// eligible cycles. Fetch is eligible only while the core is running; debug is
// eligible only while it is halted.
//
// Every handshake (req & gnt in the same cycle) is registered into a memory
// command that is presented on mem_* during the following cycle. Reads carry
// an owner tag, and the owning port sees rvalid/rdata one cycle after the
// strobe, i.e. two cycles after its handshake. Writes complete at handshake
// and never produce rvalid.
//
// Build option:
//   MIPS32_ARB_DBG_PORT_EN  when defined, the x_* debug port exists and is
//                           arbitrated at the lowest priority while halted.
//                           When undefined, the port is absent and only data
//                           and fetch are arbitrated.
//
// Parameters:
//   AW          word-address width
//   STARVE_MAX  refused fetch cycles before fetch beats data (1..15)
//
// Ports:
//   clk1, rst            clock (rising edge), asynchronous active-high reset
//   core_halted          pipeline HALTED flag, selects fetch vs debug
//   d_req/we/addr/wdata  data request; d_gnt, d_rvalid, d_rdata responses
//   i_req/addr           fetch request (read only); i_gnt, i_rvalid, i_rdata
//   x_req/we/addr/wdata  debug request; x_gnt, x_rvalid, x_rdata (option)
//   mem_en/we/addr/wdata registered memory command
//   mem_rdata            memory read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module mips32_mem_arbiter #(
  parameter int AW         = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          core_halted,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  // fetch port
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
`ifdef MIPS32_ARB_DBG_PORT_EN
  // debug/loader port
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [31:0]   x_wdata,
  output logic          x_gnt,
  output logic          x_rvalid,
  output logic [31:0]   x_rdata,
`endif
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  // Port indices double as the owner tag encodings.
  localparam int P_D = 0;
  localparam int P_I = 1;
`ifdef MIPS32_ARB_DBG_PORT_EN
  localparam int P_X   = 2;
  localparam int NPORT = 3;
`else
  localparam int NPORT = 2;
`endif

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // ---------------------------------------------------------------------------
  // Per-port request views
  // ---------------------------------------------------------------------------
  logic [NPORT-1:0]           elig_vec;
  logic [NPORT-1:0]           we_vec;
  logic [NPORT-1:0][AW-1:0]   addr_vec;
  logic [NPORT-1:0][31:0]     wdata_vec;
  logic [NPORT-1:0]           gnt_vec;
  logic [NPORT-1:0]           rvalid_vec;
  logic [NPORT-1:0][31:0]     rdata_vec;

  assign elig_vec[P_D]  = d_req;
  assign we_vec[P_D]    = d_we;
  assign addr_vec[P_D]  = d_addr;
  assign wdata_vec[P_D] = d_wdata;

  // Fetch is read-only and may only compete while the core is running.
  assign elig_vec[P_I]  = i_req & ~core_halted;
  assign we_vec[P_I]    = 1'b0;
  assign addr_vec[P_I]  = i_addr;
  assign wdata_vec[P_I] = '0;

`ifdef MIPS32_ARB_DBG_PORT_EN
  // Debug may only touch memory while the pipeline is stopped.
  assign elig_vec[P_X]  = x_req & core_halted;
  assign we_vec[P_X]    = x_we;
  assign addr_vec[P_X]  = x_addr;
  assign wdata_vec[P_X] = x_wdata;
`endif

  // ---------------------------------------------------------------------------
  // Starvation counter and arbitration
  // ---------------------------------------------------------------------------
  logic [3:0] starve_cnt_reg;
  logic [3:0] starve_cnt_next;
  logic       fetch_override;
  logic       win_any;
  logic [1:0] win_idx;

  assign fetch_override = elig_vec[P_I] && (starve_cnt_reg == STARVE_LIM);

  always_comb begin
    win_any = 1'b0;
    win_idx = 2'd0;
    // Walk from lowest to highest priority so the highest eligible port is
    // the last one written.
    for (int p = NPORT - 1; p >= 0; p--) begin
      if (elig_vec[p]) begin
        win_any = 1'b1;
        win_idx = 2'(p);
      end
    end
    // A starved fetch beats data; win_any is already set since fetch is
    // eligible whenever the override is active.
    if (fetch_override) begin
      win_idx = 2'(P_I);
    end
    // No grants while the reset is held, so all outputs read 0.
    if (rst) begin
      win_any = 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_gnt
      assign gnt_vec[gi] = win_any && (win_idx == 2'(gi));
    end
  endgenerate

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!i_req || gnt_vec[P_I]) begin
      starve_cnt_next = 4'd0;
    end else if (elig_vec[P_I] && (starve_cnt_reg != STARVE_LIM)) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
    // i_req held while halted (not eligible) keeps the count where it is.
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= 4'd0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Winner's command fields
  // ---------------------------------------------------------------------------
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (win_idx == 2'(p)) begin
        sel_we    = we_vec[p];
        sel_addr  = addr_vec[p];
        sel_wdata = wdata_vec[p];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command stage: one registered memory access per handshake
  // ---------------------------------------------------------------------------
  logic          mem_en_reg;
  logic          mem_we_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [31:0]   mem_wdata_reg;
  logic [1:0]    tag_reg;
  logic          tag_valid_reg;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      tag_reg       <= 2'd0;
      tag_valid_reg <= 1'b0;
    end else if (win_any) begin
      mem_en_reg    <= 1'b1;
      mem_we_reg    <= sel_we;
      mem_addr_reg  <= sel_addr;
      mem_wdata_reg <= sel_wdata;
      tag_reg       <= win_idx;
      // Only reads expect anything back.
      tag_valid_reg <= ~sel_we;
    end else begin
      // Address and write data hold; only the strobes drop.
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      tag_valid_reg <= 1'b0;
    end
  end

  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  // ---------------------------------------------------------------------------
  // Response stage: the memory answers during the cycle after the strobe, so
  // the tag is carried one more cycle and mem_rdata is steered straight to the
  // owner. Non-owners keep showing their last returned word.
  // ---------------------------------------------------------------------------
  logic       rsp_valid_reg;
  logic [1:0] rsp_tag_reg;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_tag_reg   <= 2'd0;
    end else begin
      rsp_valid_reg <= mem_en_reg & tag_valid_reg;
      rsp_tag_reg   <= tag_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_rsp
      logic [31:0] rdata_hold_reg;

      assign rvalid_vec[gi] = rsp_valid_reg && (rsp_tag_reg == 2'(gi));
      assign rdata_vec[gi]  = rvalid_vec[gi] ? mem_rdata : rdata_hold_reg;

      always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
          rdata_hold_reg <= '0;
        end else if (rvalid_vec[gi]) begin
          rdata_hold_reg <= mem_rdata;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Port outputs
  // ---------------------------------------------------------------------------
  assign d_gnt    = gnt_vec[P_D];
  assign d_rvalid = rvalid_vec[P_D];
  assign d_rdata  = rdata_vec[P_D];

  assign i_gnt    = gnt_vec[P_I];
  assign i_rvalid = rvalid_vec[P_I];
  assign i_rdata  = rdata_vec[P_I];

`ifdef MIPS32_ARB_DBG_PORT_EN
  assign x_gnt    = gnt_vec[P_X];
  assign x_rvalid = rvalid_vec[P_X];
  assign x_rdata  = rdata_vec[P_X];
`endif

endmodule
